// File: rtl/dds_pkg.sv
// Shared types for the phase-accumulator NCO.
package dds_pkg;

  typedef enum logic [1:0] {
    DDS_LUT,
    DDS_SAW,
    DDS_SQUARE,
    DDS_TRI
  } dds_mode_e;

endpackage

// File: rtl/dds_nco_if.sv
// Control, LUT-load and sample-output bundle for dds_nco.
interface dds_nco_if
  import dds_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int LUT_W   = 8,
  parameter int PM_W    = 12,
  parameter int AMP_W   = 16
) ();

  localparam int OUT_W = LUT_W + AMP_W + 1;

  logic [LUT_W-1:0]        lut_wdata;
  logic                    lut_we;
  logic                    lut_wptr_clr;
  logic                    en;
  logic                    phase_clr;
  logic [PHASE_W-1:0]      step;
  logic [PHASE_W-1:0]      fm_data;
  logic [PM_W-1:0]         pm_data;
  dds_mode_e               mode;
  logic [AMP_W-1:0]        amp;
  logic signed [OUT_W-1:0] out;
  logic                    out_valid;

  modport master (
    output lut_wdata, lut_we, lut_wptr_clr, en, phase_clr,
    output step, fm_data, pm_data, mode, amp,
    input  out, out_valid
  );

  modport slave (
    input  lut_wdata, lut_we, lut_wptr_clr, en, phase_clr,
    input  step, fm_data, pm_data, mode, amp,
    output out, out_valid
  );

endinterface

// File: rtl/dds_lut_ram.sv
// Simple dual-port waveform RAM: one write port, registered read-first read port.
module dds_lut_ram #(
  parameter int LUT_W  = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [LUT_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [LUT_W-1:0]  rdata
);

  logic [LUT_W-1:0] mem [2**ADDR_W];

  // Non-blocking read and write in one process give old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dds_nco.sv
// Phase-accumulator NCO: LUT or synthesized waveform, FM/PM, amplitude scaling, 3-cycle latency.
module dds_nco
  import dds_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 12,
  parameter int LUT_W   = 8,
  parameter int PM_W    = 12,
  parameter int AMP_W   = 16
) (
  input logic       clk,
  input logic       reset,
  dds_nco_if.slave  bus
);

  localparam int OUT_W = LUT_W + AMP_W + 1;

  logic [PHASE_W-1:0]      accum;
  logic [ADDR_W-1:0]       wptr, waddr, pm_ext;
  logic [ADDR_W-1:0]       addr1;
  logic                    v1, v2;
  dds_mode_e               mode1, mode2;
  logic [AMP_W-1:0]        amp1, amp2;
  logic [LUT_W-1:0]        ram_q, syn_d, syn_q;
  logic signed [LUT_W-1:0] wave;

  always_ff @(posedge clk) begin
    if (reset)              accum <= '0;
    else if (bus.phase_clr) accum <= '0;
    else if (bus.en)        accum <= accum + bus.step + bus.fm_data;
  end

  // A cleared pointer with a simultaneous write lands at 0 and moves on to 1.
  assign waddr = bus.lut_wptr_clr ? '0 : wptr;

  always_ff @(posedge clk) begin
    if (reset)                 wptr <= '0;
    else if (bus.lut_wptr_clr) wptr <= bus.lut_we ? ADDR_W'(1) : '0;
    else if (bus.lut_we)       wptr <= wptr + ADDR_W'(1);
  end

  dds_lut_ram #(.LUT_W(LUT_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (bus.lut_we),
    .waddr (waddr),
    .wdata (bus.lut_wdata),
    .raddr (addr1),
    .rdata (ram_q)
  );

  assign pm_ext = ADDR_W'($signed(bus.pm_data));

  always_ff @(posedge clk) begin
    if (reset) v1 <= 1'b0;
    else       v1 <= bus.en;
    addr1 <= accum[PHASE_W-1 -: ADDR_W] + pm_ext;
    mode1 <= bus.mode;
    amp1  <= bus.amp;
  end

  always_comb begin
    logic [LUT_W-1:0] x, y;
    x     = addr1[ADDR_W-2 -: LUT_W];
    y     = addr1[ADDR_W-1] ? ~x : x;
    syn_d = '0;
    case (mode1)
      DDS_SAW:    syn_d = {~addr1[ADDR_W-1], addr1[ADDR_W-2 -: LUT_W-1]};
      DDS_SQUARE: syn_d = addr1[ADDR_W-1] ? {1'b1, {(LUT_W-1){1'b0}}}
                                          : {1'b0, {(LUT_W-1){1'b1}}};
      DDS_TRI:    syn_d = {~y[LUT_W-1], y[LUT_W-2:0]};
      default:    syn_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) v2 <= 1'b0;
    else       v2 <= v1;
    mode2 <= mode1;
    amp2  <= amp1;
    syn_q <= syn_d;
  end

  assign wave = (mode2 == DDS_LUT) ? ram_q : syn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= v2;
      if (v2) bus.out <= OUT_W'(wave * $signed({1'b0, amp2}));
    end
  end

endmodule

// File: tb/tb_dds_nco.sv
// Directed self-checking bench for dds_nco.
module tb_dds_nco;
  import dds_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  dds_nco_if #(.PHASE_W(32), .LUT_W(8), .PM_W(12), .AMP_W(16)) bus ();

  dds_nco #(.PHASE_W(32), .ADDR_W(12), .LUT_W(8), .PM_W(12), .AMP_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ramp_val(int a);
    logic [7:0] b;
    b = a[7:0];
    return int'($signed(b));
  endfunction

  // Clears the accumulator with en low (pipeline drains), then raises en.
  // Sample k is visible after the (k+3)-th tick following this task.
  task automatic start_stream(logic [31:0] s, logic [31:0] f, logic [11:0] p,
                              dds_mode_e m, logic [15:0] a);
    bus.en        = 1'b0;
    bus.step      = s;
    bus.fm_data   = f;
    bus.pm_data   = p;
    bus.mode      = m;
    bus.amp       = a;
    bus.phase_clr = 1'b1;
    repeat (3) tick();
    bus.phase_clr = 1'b0;
    bus.en        = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out !== '0)
      $display("FAIL reset_state: out=%0d out_valid=%b, required out=0 out_valid=0",
               bus.out, bus.out_valid);
    else passed++;
  endtask

  task automatic load_ramp();
    bus.lut_wptr_clr = 1'b1;
    tick();
    bus.lut_wptr_clr = 1'b0;
    bus.lut_we       = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      bus.lut_wdata = i[7:0];
      tick();
    end
    bus.lut_we = 1'b0;
  endtask

  task automatic test_ramp(string name, int nsamp);
    int got;
    start_stream(32'h0010_0000, '0, '0, DDS_LUT, 16'd1);
    for (int t = 1; t <= nsamp + 2; t++) begin
      tick();
      got = bus.out;
      total++;
      if (t < 3) begin
        if (bus.out_valid !== 1'b0)
          $display("FAIL %s_latency t=%0d: out_valid=%b, required 0", name, t, bus.out_valid);
        else passed++;
      end else if (bus.out_valid !== 1'b1 || got !== ramp_val(t - 3)) begin
        $display("FAIL %s sample %0d: out=%0d valid=%b, required out=%0d valid=1",
                 name, t - 3, got, bus.out_valid, ramp_val(t - 3));
      end else passed++;
    end
    bus.en = 1'b0;
  endtask

  task automatic test_wrap();
    int got;
    int ev_sq[4]  = '{127, -128, 127, -128};
    int ev_lut[4] = '{0, 0, 0, 0};
    for (int m = 0; m < 2; m++) begin
      start_stream(32'h8000_0000, '0, '0, (m == 0) ? DDS_SQUARE : DDS_LUT, 16'd1);
      repeat (2) tick();
      for (int k = 0; k < 4; k++) begin
        tick();
        got = bus.out;
        total++;
        if (bus.out_valid !== 1'b1 || got !== ((m == 0) ? ev_sq[k] : ev_lut[k]))
          $display("FAIL wrap mode%0d sample %0d: out=%0d valid=%b, required %0d",
                   m, k, got, bus.out_valid, (m == 0) ? ev_sq[k] : ev_lut[k]);
        else passed++;
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_pm_fm();
    int got;
    start_stream('0, '0, 12'hFFF, DDS_LUT, 16'd1);
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin
      tick();
      got = bus.out;
      total++;
      if (bus.out_valid !== 1'b1 || got !== -1)
        $display("FAIL pm_wrap sample %0d: out=%0d valid=%b, required -1", k, got, bus.out_valid);
      else passed++;
    end
    start_stream(32'h0020_0000, 32'hFFF0_0000, '0, DDS_LUT, 16'd1);
    repeat (2) tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      got = bus.out;
      total++;
      if (bus.out_valid !== 1'b1 || got !== k)
        $display("FAIL fm sample %0d: out=%0d valid=%b, required %0d", k, got, bus.out_valid, k);
      else passed++;
    end
    bus.en = 1'b0;
  endtask

  task automatic test_modes();
    int got;
    dds_mode_e modes[3] = '{DDS_SQUARE, DDS_SAW, DDS_TRI};
    int nchk[3]         = '{4, 2, 2};
    int at[3][4]        = '{'{0, 1024, 2048, 3072}, '{0, 1024, 0, 0}, '{0, 2047, 0, 0}};
    int ev[3][4]        = '{'{254, 254, -256, -256}, '{-256, -128, 0, 0}, '{-256, 254, 0, 0}};
    for (int m = 0; m < 3; m++) begin
      start_stream(32'h0010_0000, '0, '0, modes[m], 16'd2);
      for (int t = 1; t <= at[m][nchk[m]-1] + 3; t++) begin
        tick();
        got = bus.out;
        for (int j = 0; j < nchk[m]; j++) begin
          if (t == at[m][j] + 3) begin
            total++;
            if (bus.out_valid !== 1'b1 || got !== ev[m][j])
              $display("FAIL mode_%s addr %0d: out=%0d valid=%b, required %0d",
                       modes[m].name(), at[m][j], got, bus.out_valid, ev[m][j]);
            else passed++;
          end
        end
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_phase_clr();
    int got;
    int ev[3] = '{0, 35, 0};
    start_stream(32'h1234_0000, '0, '0, DDS_LUT, 16'd1);
    tick();
    bus.phase_clr = 1'b1;
    bus.step      = 32'h0010_0000;
    tick();
    bus.phase_clr = 1'b0;
    tick();
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      got = bus.out;
      total++;
      if (bus.out_valid !== 1'b1 || got !== ev[k])
        $display("FAIL phase_clr sample %0d: out=%0d valid=%b, required %0d",
                 k, got, bus.out_valid, ev[k]);
      else passed++;
      tick();
    end
    total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL drain: out_valid=%b, required 0", bus.out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int budget = 10;
    start_stream(32'h0010_0000, '0, '0, DDS_LUT, 16'd1);
    repeat (5) tick();
    while (bus.out_valid !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    total++;
    if (bus.out_valid !== 1'b1) begin
      $display("FAIL reset_mid_wait: out_valid=%b, required 1 within budget", bus.out_valid);
    end else begin
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      bus.en = 1'b0;
      if (bus.out_valid !== 1'b0 || bus.out !== '0)
        $display("FAIL reset_mid: out=%0d valid=%b, required out=0 valid=0",
                 bus.out, bus.out_valid);
      else passed++;
    end
    reset  = 1'b0;
    bus.en = 1'b0;
  endtask

  task automatic test_wptr();
    int got;
    int ev[3] = '{-91, 90, 2};
    bus.lut_we       = 1'b1;
    bus.lut_wptr_clr = 1'b1;
    bus.lut_wdata    = 8'hA5;
    tick();
    bus.lut_wptr_clr = 1'b0;
    bus.lut_wdata    = 8'h5A;
    tick();
    bus.lut_we = 1'b0;
    start_stream(32'h0010_0000, '0, '0, DDS_LUT, 16'd1);
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      got = bus.out;
      total++;
      if (bus.out_valid !== 1'b1 || got !== ev[k])
        $display("FAIL wptr sample %0d: out=%0d valid=%b, required %0d",
                 k, got, bus.out_valid, ev[k]);
      else passed++;
    end
    bus.en = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    bus.lut_wdata    = '0;
    bus.lut_we       = 1'b0;
    bus.lut_wptr_clr = 1'b0;
    bus.en           = 1'b0;
    bus.phase_clr    = 1'b0;
    bus.step         = '0;
    bus.fm_data      = '0;
    bus.pm_data      = '0;
    bus.mode         = DDS_LUT;
    bus.amp          = '0;
    test_reset();
    load_ramp();
    test_ramp("ramp", 300);
    test_wrap();
    test_pm_fm();
    test_modes();
    test_phase_clr();
    test_reset_mid();
    test_ramp("rerun", 260);
    test_wptr();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
